// File: rtl/dac_serial.sv
// Ideal serial-load DAC: MSB-first frame into a shift register, double-buffered via hreg,
// and a real-valued mid-code reconstruction output between out_min and out_max.
module dac_serial #(
    parameter int unsigned BITW      = 8,
    parameter bit          AUTO_LOAD = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    input  real             out_min,
    input  real             out_max,
    input  logic            sen,
    input  logic            sdi,
    input  logic            ldac,
    output logic            frame_done,
    output logic [BITW-1:0] code,
    output real             out,
    output real             lsb
);

    localparam int unsigned   CW      = $clog2(BITW + 1);
    localparam logic [CW-1:0] LastBit = CW'(BITW - 1);

    logic [BITW-1:0] sreg_q, sreg_d;
    logic [BITW-1:0] hreg_q, hreg_d;
    logic [BITW-1:0] code_q, code_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [BITW-1:0] shifted;
    logic            complete;
    real             step;

    always_comb begin
        shifted  = {sreg_q[BITW-2:0], sdi};
        complete = sen && (cnt_q == LastBit);

        sreg_d = sen ? shifted : sreg_q;
        hreg_d = complete ? shifted : hreg_q;
        done_d = complete;
        // Dropping sen, or finishing a frame, restarts the bit count.
        cnt_d  = (!sen || complete) ? '0 : cnt_q + CW'(1);

        code_d = code_q;
        if (AUTO_LOAD) begin
            if (complete) code_d = shifted;
        end else if (ldac) begin
            // A frame completing on the load edge bypasses the holding register.
            code_d = complete ? shifted : hreg_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sreg_q <= '0;
            hreg_q <= '0;
            code_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            hreg_q <= hreg_d;
            code_q <= code_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign code       = code_q;
    assign frame_done = done_q;

    // Mid-code reconstruction; no clipping, a reversed range simply mirrors the output.
    always_comb begin
        step = (out_max - out_min) / (2.0 ** BITW);
        lsb  = step;
        out  = out_min + (real'(code_q) + 0.5) * step;
    end

endmodule
